divider: RTL and testbench

Multi-cycle 32-bit integer divider that implements the inverse of the ALU's single-cycle MULU/MULS operations. It uses one radix-2 restoring step per clock. It sits beside the ALU in the execute stage: the control unit pulses `start`, stalls while `busy` is high, and writes back `quotient`/`remainder` when `done` pulses. Flag outputs follow the ALU's zero/neg/over conventions so the status register can take either source.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider.sv | 180 ++++++++++++++++++
 tb/tb_divider.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the multi-cycle integer divider that sits beside
//   the ALU in the execute stage.
//
//   div_op_e    : operation select carried on the divider's signed_op input
//                 (OP_DIVU = unsigned divide, OP_DIVS = signed divide).
//   div_state_e : divider FSM state encoding (IDLE, ITERATE, FIXUP).
// -----------------------------------------------------------------------------
package divider_pkg;

  // Operation select, matching the one-bit signed_op input of the divider.
  typedef enum logic {
    OP_DIVU = 1'b0,
    OP_DIVS = 1'b1
  } div_op_e;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_ITERATE = 2'd1,
    DIV_FIXUP   = 2'd2
  } div_state_e;

endpackage : divider_pkg

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Multi-cycle WIDTH-bit integer divider (DIVU / DIVS), one radix-2 restoring
//   step per clock. A start seen in IDLE captures the operands; ITERATE runs
//   WIDTH steps on the operand magnitudes; FIXUP applies the signs, writes the
//   registered results and flags, and pulses done. Divide-by-zero skips
//   ITERATE and goes straight to FIXUP.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low; clears all state and outputs
//   start       in   request a divide; only honoured in IDLE
//   signed_op   in   1 = DIVS, 0 = DIVU; captured with start
//   dividend    in   numerator; captured with start
//   divisor     in   denominator; captured with start
//   busy        out  high from the start edge until the done edge
//   done        out  one-cycle pulse; results valid from this cycle on
//   quotient    out  registered quotient, held until the next done
//   remainder   out  registered remainder, held until the next done
//   zero_out    out  quotient == 0
//   neg_out     out  quotient sign bit
//   over_out    out  signed overflow (most-negative / -1)
//   div_by_zero out  divisor was zero
// -----------------------------------------------------------------------------
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zero_out,
  output logic             neg_out,
  output logic             over_out,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dsr_mag;
  logic             q_neg;
  logic             r_neg;
  logic             zero_div;
  logic             ovf;

  // Operand sign decode at the start edge.
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // One restoring step and the final sign fix-up.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  always_comb begin
    is_signed = (signed_op == OP_DIVS);
    a_neg     = is_signed && dividend[WIDTH-1];
    b_neg     = is_signed && divisor[WIDTH-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor  : divisor;
  end

  // The trial difference is WIDTH+1 bits so its top bit is the borrow; the
  // shifted partial remainder can exceed WIDTH bits before subtraction.
  always_comb begin
    shifted = {part_rem, quo_reg[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_mag};
  end

  // On a zero divide quo_reg holds the raw dividend, returned as remainder.
  // Most-negative / -1 needs no special path: the magnitude quotient
  // negates back to most-negative and the remainder is already zero.
  always_comb begin
    fin_q = '0;
    fin_r = '0;
    if (zero_div) begin
      fin_q = '1;
      fin_r = quo_reg;
    end else begin
      fin_q = q_neg ? -quo_reg  : quo_reg;
      fin_r = r_neg ? -part_rem : part_rem;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= DIV_IDLE;
      step_cnt    <= '0;
      part_rem    <= '0;
      quo_reg     <= '0;
      dsr_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero_div    <= 1'b0;
      ovf         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      zero_out    <= 1'b0;
      neg_out     <= 1'b0;
      over_out    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            ovf      <= is_signed && (dividend == MOST_NEG) && (&divisor);
            part_rem <= '0;
            dsr_mag  <= b_mag;
            step_cnt <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              zero_div <= 1'b1;
              quo_reg  <= dividend;
              state    <= DIV_FIXUP;
            end else begin
              zero_div <= 1'b0;
              quo_reg  <= a_mag;
              state    <= DIV_ITERATE;
            end
          end
        end

        DIV_ITERATE: begin
          // Quotient bits shift into quo_reg as dividend bits shift out.
          if (!trial[WIDTH]) begin
            part_rem <= trial[WIDTH-1:0];
            quo_reg  <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            part_rem <= shifted[WIDTH-1:0];
            quo_reg  <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          if (step_cnt == '0) begin
            state <= DIV_FIXUP;
          end else begin
            step_cnt <= step_cnt - CW'(1);
          end
        end

        DIV_FIXUP: begin
          quotient    <= fin_q;
          remainder   <= fin_r;
          zero_out    <= (fin_q == '0);
          neg_out     <= fin_q[WIDTH-1];
          over_out    <= ovf;
          div_by_zero <= zero_div;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= DIV_IDLE;
        end

        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule : divider

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for the divider: a table of directed vectors, a few
//   random vectors checked against a behavioural model, and hand-written
//   sequences for the done pulse, start-while-busy and mid-operation reset.
//   Expected results are queued when a start is driven and popped when the
//   divider pulses done.
// -----------------------------------------------------------------------------
module tb_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        zero_out;
  logic        neg_out;
  logic        over_out;
  logic        div_by_zero;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        zero;
    logic        neg;
    logic        over;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        zero;
    logic        neg;
    logic        over;
    logic        dz;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  divider #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .zero_out    (zero_out),
    .neg_out     (neg_out),
    .over_out    (over_out),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  // Edge counter used to measure start-to-done latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic compareValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: SV integer division truncates toward zero and
  // gives the remainder the dividend's sign.
  function automatic exp_t modelDivide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb_v;
    e.over = 1'b0;
    e.dz   = 1'b0;
    e.lat  = 33;
    e.start_cyc = 0;
    if (b == 32'd0) begin
      e.q   = 32'hffffffff;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else if (sgn && a == 32'h80000000 && b == 32'hffffffff) begin
      e.q    = 32'h80000000;
      e.r    = 32'd0;
      e.over = 1'b1;
    end else if (sgn) begin
      sa   = $signed(a);
      sb_v = $signed(b);
      e.q  = 32'(sa / sb_v);
      e.r  = 32'(sa % sb_v);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    e.zero = (e.q == 32'd0);
    e.neg  = e.q[31];
    return e;
  endfunction

  function automatic exp_t vecToExp(input vec_t v);
    exp_t e;
    e.q = v.q; e.r = v.r; e.zero = v.zero; e.neg = v.neg;
    e.over = v.over; e.dz = v.dz; e.lat = v.lat; e.start_cyc = 0;
    return e;
  endfunction

  // Called at a negedge: drives a start for the next edge, queues the
  // expectation, then drops start and scrambles the operand inputs.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start     = 1'b0;
    signed_op = ~sgn;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Waits (bounded) for done, returning at the negedge where done is high.
  task automatic checkOutput(input string tag);
    exp_t e;
    bit   got     = 1'b0;
    bit   busy_ok = busy;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    if (!got) begin
      compareValue({tag, ".done_seen"}, 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      compareValue({tag, ".expected_pending"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    compareValue({tag, ".quotient"},    64'(quotient),    64'(e.q));
    compareValue({tag, ".remainder"},   64'(remainder),   64'(e.r));
    compareValue({tag, ".zero_out"},    64'(zero_out),    64'(e.zero));
    compareValue({tag, ".neg_out"},     64'(neg_out),     64'(e.neg));
    compareValue({tag, ".over_out"},    64'(over_out),    64'(e.over));
    compareValue({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
    compareValue({tag, ".latency"},     64'(cyc - e.start_cyc), 64'(e.lat));
    compareValue({tag, ".busy_while_running"}, 64'(busy_ok), 64'd1);
    compareValue({tag, ".busy_at_done"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [69:0] allOutputs();
    return {busy, done, quotient, remainder, zero_out, neg_out, over_out, div_by_zero};
  endfunction

  initial begin
    exp_t        e;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_count;

    //          sgn   dividend      divisor       quotient      remainder     z     n     o     dz   lat
    vecs[0] = '{1'b0, 32'd100,      32'd7,        32'h0000000e, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 33};
    vecs[1] = '{1'b1, 32'hfffffff9, 32'h00000002, 32'hfffffffd, 32'hffffffff, 1'b0, 1'b1, 1'b0, 1'b0, 33};
    vecs[2] = '{1'b1, 32'd7,        32'hfffffffe, 32'hfffffffd, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 33};
    vecs[3] = '{1'b0, 32'h12345678, 32'h00000000, 32'hffffffff, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[4] = '{1'b0, 32'hffffffff, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 33};
    vecs[5] = '{1'b1, 32'h80000000, 32'hffffffff, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 33};
    vecs[6] = '{1'b0, 32'd3,        32'd5,        32'h00000000, 32'h00000003, 1'b1, 1'b0, 1'b0, 1'b0, 33};
    vecs[7] = '{1'b1, 32'h80000000, 32'h00000000, 32'hffffffff, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    vecs[8] = '{1'b1, 32'hffffff9c, 32'hfffffff9, 32'h0000000e, 32'hfffffffe, 1'b0, 1'b0, 1'b0, 1'b0, 33};
    vecs[9] = '{1'b0, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 33};

    // Reset state, both while held and just after release.
    repeat (3) @(negedge clock);
    compareValue("reset_held.outputs", 64'(allOutputs()), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    compareValue("reset_released.outputs", 64'(allOutputs()), 64'd0);

    // First divide on its own, then check done is a single-cycle pulse.
    applyStimulus(vecs[0].sgn, vecs[0].a, vecs[0].b, vecToExp(vecs[0]));
    checkOutput("divu_100_7");
    @(negedge clock);
    compareValue("done_pulse.falls", 64'(done), 64'd0);
    compareValue("done_pulse.quotient_held", 64'(quotient), 64'h0000000e);

    // Remaining table vectors run back-to-back: each start is driven during
    // the previous done cycle.
    for (int i = 1; i < 10; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecToExp(vecs[i]));
      checkOutput($sformatf("vec%0d", i));
    end

    // Random vectors against the model.
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 4) rb = 32'd0;
      @(negedge clock);
      applyStimulus(rs, ra, rb, modelDivide(rs, ra, rb));
      checkOutput($sformatf("rand%0d", i));
    end

    // A start with new operands mid-ITERATE must be ignored.
    @(negedge clock);
    applyStimulus(1'b0, 32'd1000, 32'd10, modelDivide(1'b0, 32'd1000, 32'd10));
    repeat (5) @(negedge clock);
    start = 1'b1; signed_op = 1'b1; dividend = 32'd5; divisor = 32'd1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("start_while_busy");

    // Leave non-zero results/flags, then reset part-way through a divide.
    @(negedge clock);
    applyStimulus(1'b0, 32'hdeadbeef, 32'd0, modelDivide(1'b0, 32'hdeadbeef, 32'd0));
    checkOutput("div0_before_reset");
    @(negedge clock);
    applyStimulus(1'b0, 32'd1000, 32'd10, modelDivide(1'b0, 32'd1000, 32'd10));
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    compareValue("mid_reset.outputs", 64'(allOutputs()), 64'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    done_count = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) done_count++;
    end
    compareValue("after_reset.no_done", 64'(done_count), 64'd0);
    compareValue("after_reset.idle_outputs", 64'(allOutputs()), 64'd0);

    // Fresh divide after reset.
    applyStimulus(1'b1, 32'hffffff9c, 32'd7, modelDivide(1'b1, 32'hffffff9c, 32'd7));
    checkOutput("after_reset.divs");
    compareValue("after_reset.quotient_const", 64'(quotient), 64'hfffffff2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_divider
